// File: rtl/ladybird_lsu_pkg.sv
// rtl/ladybird_lsu_pkg.sv - shared types and helpers for the ladybird load/store unit
package ladybird_lsu_pkg;

  // Access size, taken from funct3[1:0]
  typedef enum logic [1:0] {
    LSU_B = 2'd0,
    LSU_H = 2'd1,
    LSU_W = 2'd2,
    LSU_D = 2'd3
  } lsu_size_t;

  // One outstanding request, as it waits in the tag FIFO for its response
  typedef struct packed {
    logic [2:0] funct3;
    logic [2:0] offset;
    logic [4:0] rd;
    logic       store;
    logic       error;
  } lsu_entry_t;

  // True when the access cannot be issued: unaligned address or a size/sign
  // combination that does not exist for this XLEN
  function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                          input logic [2:0] addr_lo,
                                          input logic       xlen64);
    logic bad;
    bad = (funct3 == 3'b111) ||
          (!xlen64 && ((funct3 == 3'b011) || (funct3 == 3'b110)));
    case (funct3[1:0])
      LSU_B:   bad = bad;
      LSU_H:   bad = bad | addr_lo[0];
      LSU_W:   bad = bad | (|addr_lo[1:0]);
      default: bad = bad | (|addr_lo);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ladybird_lsu_tag_fifo.sv
// rtl/ladybird_lsu_tag_fifo.sv - in-order FIFO of outstanding request tags
module ladybird_lsu_tag_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic clk,
  input  logic anrst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  T                mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem_q[rd_ptr];

  // Entry storage; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= din;
  end

  // Pointers and occupancy; push+pop together leaves count unchanged
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ladybird_lsu.sv
// rtl/ladybird_lsu.sv - load/store unit between execute stage and ladybird_mmu
module ladybird_lsu
  import ladybird_lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              anrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [2:0]        req_funct3,
  input  logic              req_store,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              mem_rready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_store,
  output logic              rsp_error
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  logic            misaligned;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  lsu_entry_t      push_entry;
  lsu_entry_t      head;
  logic [OW-1:0]   req_off;
  logic [3:0]      req_bytes;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic            sbit;
  logic [XLEN-1:0] load_data;

  assign req_off    = req_addr[OW-1:0];
  assign req_bytes  = 4'd1 << req_funct3[1:0];
  assign misaligned = lsu_misaligned(req_funct3, req_addr[2:0], 1'(XLEN == 64));

  // Misaligned requests skip the memory and go straight into the FIFO as errors
  assign mem_valid  = req_valid & ~fifo_full & ~misaligned;
  assign req_ready  = ~fifo_full & (misaligned | mem_ready);
  assign push       = req_valid & req_ready;
  assign mem_addr   = {req_addr[XLEN-1:OW], OW'(0)};
  assign push_entry = '{funct3: req_funct3, offset: 3'(req_off), rd: req_rd,
                        store: req_store, error: misaligned};

  // Replicate store data across lanes and strobe only the addressed bytes
  always_comb begin
    mem_wdata = '0;
    mem_wstrb = '0;
    for (int i = 0; i < NB; i++) begin
      mem_wdata[8*i +: 8] = req_wdata[8*(i & (int'(req_bytes) - 1)) +: 8];
      if (req_store && (i >= int'(req_off)) && (i < int'(req_off) + int'(req_bytes)))
        mem_wstrb[i] = 1'b1;
    end
  end

  ladybird_lsu_tag_fifo #(
    .DEPTH (DEPTH),
    .T     (lsu_entry_t)
  ) u_fifo (
    .clk   (clk),
    .anrst (anrst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign shifted = mem_rdata >> {head.offset, 3'b000};

  // Keep the accessed bytes, then sign- or zero-fill the rest
  always_comb begin
    keep = '1;
    sbit = 1'b0;
    case (head.funct3[1:0])
      LSU_B:   begin keep = XLEN'(8'hFF);          sbit = shifted[7];  end
      LSU_H:   begin keep = XLEN'(16'hFFFF);       sbit = shifted[15]; end
      LSU_W:   begin keep = XLEN'(32'hFFFF_FFFF);  sbit = shifted[31]; end
      default: begin keep = '1;                    sbit = 1'b0;        end
    endcase
    load_data = (shifted & keep) | ((sbit & ~head.funct3[2]) ? ~keep : '0);
  end

  // Error entries answer immediately at the head; others wait for the memory beat
  assign rsp_valid  = ~fifo_empty & (head.error | mem_rvalid);
  assign mem_rready = ~fifo_empty & ~head.error & rsp_ready;
  assign pop        = rsp_valid & rsp_ready;
  assign rsp_data   = (head.error | head.store) ? '0 : load_data;
  assign rsp_rd     = head.rd;
  assign rsp_store  = head.store;
  assign rsp_error  = head.error;

  // A memory beat with nothing outstanding means the mmu broke protocol
  assert property (@(posedge clk) disable iff (!anrst) !(mem_rvalid && fifo_empty));

endmodule

// File: tb/tb_ladybird_lsu.sv
// tb/tb_ladybird_lsu.sv - self-checking bench for ladybird_lsu
module tb_ladybird_lsu;

  localparam int DEPTH = 2;

  logic        clk;
  logic        anrst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic        req_store;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_store;
  logic        rsp_error;

  int checks = 0;
  int errors = 0;

  ladybird_lsu #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .anrst      (anrst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_store  (req_store),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_rready (mem_rready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_rd     (rsp_rd),
    .rsp_store  (rsp_store),
    .rsp_error  (rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] f;
    logic [1:0] off;
    logic [4:0] rd;
    logic       st;
    logic       err;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic logic mis(input logic [31:0] a, input logic [2:0] f);
    return (f == 3'b111) || (f == 3'b011) || (f == 3'b110) || ((a % nbytes(f)) != 0);
  endfunction

  function automatic logic [31:0] ext_load(input logic [31:0] rdata, input ent_t e);
    int nb;
    logic [63:0] v;
    logic [63:0] m;
    nb = nbytes(e.f);
    v  = 64'(rdata) >> (8 * e.off);
    m  = (64'd1 << (8 * nb)) - 64'd1;
    v  = v & m;
    if (!e.f[2] && v[8*nb-1]) v = v | ~m;
    return v[31:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [2:0] f);
    int nb;
    logic [63:0] m;
    logic [63:0] p;
    nb = nbytes(f);
    m  = (64'd1 << (8 * nb)) - 64'd1;
    p  = (64'(wd) & m) * ((nb == 1) ? 64'h01010101 : (nb == 2) ? 64'h00010001 : 64'h1);
    return p[31:0];
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [31:0] a, input logic [2:0] f);
    logic [7:0] s;
    s = 8'(((1 << nbytes(f)) - 1) << a[1:0]);
    return s[3:0];
  endfunction

  // Reference model: queue of outstanding requests
  always @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      q.delete();
    end else begin
      logic e_full, e_mis, e_ready, e_rvalid;
      ent_t e;
      e_full   = (q.size() == DEPTH);
      e_mis    = mis(req_addr, req_funct3);
      e_ready  = !e_full && (e_mis || mem_ready);
      e_rvalid = (q.size() > 0) && (q[0].err || mem_rvalid);
      if (e_rvalid && rsp_ready) void'(q.pop_front());
      if (req_valid && e_ready) begin
        e.f = req_funct3; e.off = req_addr[1:0]; e.rd = req_rd;
        e.st = req_store; e.err = e_mis;
        q.push_back(e);
      end
    end
  end

  // Per-cycle comparison of every meaningful output against the model
  always @(negedge clk) begin
    if (!anrst) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_mem_rready", mem_rready, 0);
    end else begin
      logic e_full, e_mis, e_ready, e_mvalid, e_rvalid, e_rready;
      e_full   = (q.size() == DEPTH);
      e_mis    = mis(req_addr, req_funct3);
      e_ready  = !e_full && (e_mis || mem_ready);
      e_mvalid = req_valid && !e_full && !e_mis;
      chk("req_ready", req_ready, e_ready);
      chk("mem_valid", mem_valid, e_mvalid);
      if (e_mvalid) begin
        chk("mem_addr", mem_addr, req_addr & 32'hFFFF_FFFC);
        chk("mem_wstrb", mem_wstrb, req_store ? exp_wstrb(req_addr, req_funct3) : 4'h0);
        if (req_store) chk("mem_wdata", mem_wdata, exp_wdata(req_wdata, req_funct3));
      end
      e_rvalid = (q.size() > 0) && (q[0].err || mem_rvalid);
      e_rready = (q.size() > 0) && !q[0].err && rsp_ready;
      chk("rsp_valid", rsp_valid, e_rvalid);
      chk("mem_rready", mem_rready, e_rready);
      if (e_rvalid) begin
        chk("rsp_rd", rsp_rd, q[0].rd);
        chk("rsp_store", rsp_store, q[0].st);
        chk("rsp_error", rsp_error, q[0].err);
        chk("rsp_data", rsp_data, (q[0].err || q[0].st) ? 32'h0 : ext_load(mem_rdata, q[0]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [2:0] f, input logic st,
                         input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_addr = a; req_funct3 = f;
    req_store = st; req_wdata = wd; req_rd = rd;
  endtask

  // Called at a negedge with a request presented; returns just after acceptance
  task automatic accept();
    for (int n = 0; n < 20; n++) begin
      if (req_ready) begin
        cyc();
        req_valid = 1'b0;
        return;
      end
      cyc();
      @(negedge clk);
    end
    chk("accept_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    mem_rvalid = 1'b1; mem_rdata = d; rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_beat();
    cyc();
    mem_rvalid = 1'b0; rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    anrst = 1'b0; req_valid = 1'b0; req_addr = '0; req_funct3 = '0;
    req_store = 1'b0; req_wdata = '0; req_rd = '0; mem_ready = 1'b1;
    mem_rvalid = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;

    // Reset: req_ready follows mem_ready
    @(negedge clk);
    chk("reset_ready_hi", req_ready, 1);
    cyc(); mem_ready = 1'b0;
    @(negedge clk);
    chk("reset_ready_lo", req_ready, 0);
    cyc(); anrst = 1'b1; mem_ready = 1'b1;

    // SW 0xDEADBEEF @0x100
    set_req(32'h100, 3'b010, 1'b1, 32'hDEAD_BEEF, 5'd1);
    @(negedge clk);
    chk("t1_mem_valid", mem_valid, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_wstrb", mem_wstrb, 4'b1111);
    chk("t1_wdata", mem_wdata, 32'hDEAD_BEEF);
    accept();
    beat(32'h0);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_store", rsp_store, 1);
    chk("t1_rsp_error", rsp_error, 0);
    end_beat();

    // SB 0xA5 @0x103
    set_req(32'h103, 3'b000, 1'b1, 32'h0000_00A5, 5'd2);
    @(negedge clk);
    chk("t2_mem_addr", mem_addr, 32'h100);
    chk("t2_wstrb", mem_wstrb, 4'b1000);
    chk("t2_wdata", mem_wdata, 32'hA5A5_A5A5);
    accept();
    beat(32'h0); end_beat();

    // LB / LBU @0x102, LH / LHU @0x102
    set_req(32'h102, 3'b000, 1'b0, 32'h0, 5'd3);
    @(negedge clk); accept();
    beat(32'h0080_0000);
    chk("t3_lb", rsp_data, 32'hFFFF_FF80);
    end_beat();
    set_req(32'h102, 3'b100, 1'b0, 32'h0, 5'd4);
    @(negedge clk); accept();
    beat(32'h0080_0000);
    chk("t3_lbu", rsp_data, 32'h0000_0080);
    end_beat();
    set_req(32'h102, 3'b001, 1'b0, 32'h0, 5'd12);
    @(negedge clk); accept();
    beat(32'h8001_0000);
    chk("t3_lh", rsp_data, 32'hFFFF_8001);
    end_beat();
    set_req(32'h102, 3'b101, 1'b0, 32'h0, 5'd13);
    @(negedge clk); accept();
    beat(32'h8001_0000);
    chk("t3_lhu", rsp_data, 32'h0000_8001);
    end_beat();

    // Misaligned LH behind a pending LW keeps order
    set_req(32'h200, 3'b010, 1'b0, 32'h0, 5'd5);
    @(negedge clk); accept();
    set_req(32'h101, 3'b001, 1'b0, 32'h0, 5'd6);
    @(negedge clk);
    chk("t4_no_mem_valid", mem_valid, 0);
    chk("t4_ready", req_ready, 1);
    accept();
    @(negedge clk);
    chk("t4_wait_lw", rsp_valid, 0);
    cyc();
    beat(32'h1234_5678);
    chk("t4_lw_rd", rsp_rd, 5);
    chk("t4_lw_data", rsp_data, 32'h1234_5678);
    chk("t4_lw_err", rsp_error, 0);
    end_beat();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_err_valid", rsp_valid, 1);
    chk("t4_err_rd", rsp_rd, 6);
    chk("t4_err", rsp_error, 1);
    chk("t4_err_data", rsp_data, 0);
    chk("t4_err_rready", mem_rready, 0);
    cyc(); rsp_ready = 1'b0;

    // DEPTH=2: third LW stalls, no pop bypass
    set_req(32'h300, 3'b010, 1'b0, 32'h0, 5'd7);
    @(negedge clk); accept();
    set_req(32'h304, 3'b010, 1'b0, 32'h0, 5'd8);
    @(negedge clk); accept();
    set_req(32'h308, 3'b010, 1'b0, 32'h0, 5'd9);
    @(negedge clk);
    chk("t5_stall", req_ready, 0);
    chk("t5_stall_mv", mem_valid, 0);
    cyc();
    @(negedge clk);
    chk("t5_stall2", req_ready, 0);
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_0001; rsp_ready = 1'b1;
    @(negedge clk);
    chk("t5_first_rd", rsp_rd, 7);
    chk("t5_first_data", rsp_data, 32'hAAAA_0001);
    chk("t5_no_bypass", req_ready, 0);
    cyc(); mem_rvalid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    chk("t5_unstall", req_ready, 1);
    accept();

    // Reset with two outstanding, then clean restart
    anrst = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_mem_rready", mem_rready, 0);
    cyc(); anrst = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    chk("t6_empty", rsp_valid, 0);
    cyc();
    set_req(32'h400, 3'b010, 1'b0, 32'h0, 5'd10);
    @(negedge clk);
    chk("t6_ready1", req_ready, 1);
    accept();
    set_req(32'h404, 3'b010, 1'b0, 32'h0, 5'd11);
    @(negedge clk);
    chk("t6_ready2", req_ready, 1);
    accept();
    beat(32'h1111_1111);
    chk("t6_rd10", rsp_rd, 10);
    chk("t6_d10", rsp_data, 32'h1111_1111);
    end_beat();
    beat(32'h2222_2222);
    chk("t6_rd11", rsp_rd, 11);
    chk("t6_d11", rsp_data, 32'h2222_2222);
    end_beat();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
